// File: rtl/pipelined_left_shifter_pkg.sv
// Shared widths, per-stage shift distances and the stage record
// used by every file of the pipelined left shifter.
package pipelined_left_shifter_pkg;

  localparam int DATA_W     = 32'sd32;
  localparam int AMT_W      = 32'sd5;
  localparam int TAG_W      = 32'sd4;
  localparam int NUM_STAGES = 32'sd5;

  localparam int SHIFT_S1 = 32'sd16;
  localparam int SHIFT_S2 = 32'sd8;
  localparam int SHIFT_S3 = 32'sd4;
  localparam int SHIFT_S4 = 32'sd2;
  localparam int SHIFT_S5 = 32'sd1;

  typedef struct packed {
    logic              valid;
    logic [DATA_W-1:0] data;
    logic [AMT_W-1:0]  amount;
    logic [TAG_W-1:0]  tag;
  } stage_t;

  localparam stage_t STAGE_RESET = '{
    valid:  1'b0,
    data:   {DATA_W{1'b0}},
    amount: {AMT_W{1'b0}},
    tag:    {TAG_W{1'b0}}
  };

  function automatic int stage_shift(input int stage);
    case (stage)
      32'sd1:  return SHIFT_S1;
      32'sd2:  return SHIFT_S2;
      32'sd3:  return SHIFT_S3;
      32'sd4:  return SHIFT_S4;
      32'sd5:  return SHIFT_S5;
      default: return 32'sd0;
    endcase
  endfunction

endpackage

// File: rtl/pipelined_left_shifter_if.sv
// Request/result handshake bundle of the pipelined left shifter.
interface pipelined_left_shifter_if;
  import pipelined_left_shifter_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_x;
  logic [AMT_W-1:0]  in_amount;
  logic [TAG_W-1:0]  in_tag;
  logic              flush;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [TAG_W-1:0]  out_tag;

  modport master (
    output in_valid, in_x, in_amount, in_tag, flush, out_ready,
    input  in_ready, out_valid, out_data, out_tag
  );

  modport slave (
    input  in_valid, in_x, in_amount, in_tag, flush, out_ready,
    output in_ready, out_valid, out_data, out_tag
  );

endinterface

// File: rtl/left_shift_stage.sv
// One registered pipeline stage: shifts by a fixed SHIFT when amount bit
// BIT_IDX is set, then retires that bit from the carried amount.
module left_shift_stage
  import pipelined_left_shifter_pkg::*;
#(
  parameter int SHIFT   = 32'sd1,
  parameter int BIT_IDX = 32'sd0
) (
  input  logic   clock,
  input  logic   reset,
  input  logic   flush,
  input  logic   advance,
  input  stage_t prev,
  output stage_t cur
);

  stage_t            cur_r;
  logic [DATA_W-1:0] shifted_s;
  logic [AMT_W-1:0]  remaining_s;

  // Fixed-distance shift selected by this stage's amount bit.
  always_comb begin
    shifted_s   = prev.data;
    remaining_s = prev.amount;
    if (prev.amount[BIT_IDX]) begin
      shifted_s = prev.data << SHIFT;
    end else begin
      shifted_s = prev.data;
    end
    remaining_s[BIT_IDX] = 1'b0;
  end

  // Stage register; payload only loads with a valid request so bubbles leave it untouched.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cur_r <= STAGE_RESET;
    end else if (flush) begin
      cur_r.valid <= 1'b0;
    end else if (advance) begin
      cur_r.valid <= prev.valid;
      if (prev.valid) begin
        cur_r.data   <= shifted_s;
        cur_r.amount <= remaining_s;
        cur_r.tag    <= prev.tag;
      end
    end
  end

  assign cur = cur_r;

endmodule

// File: rtl/pipelined_left_shifter.sv
// Five-stage logical left shifter (16/8/4/2/1) with valid/ready flow
// control, flush, and outputs taken straight from the last stage.
module pipelined_left_shifter
  import pipelined_left_shifter_pkg::*;
(
  input logic                     clock,
  input logic                     reset,
  pipelined_left_shifter_if.slave bus
);

  stage_t                stages_s [1:NUM_STAGES];
  stage_t                request_s;
  logic [NUM_STAGES:1]   advance_s;
  logic                  hole_s;
  logic                  in_ready_s;

  // A stage moves when it, or any stage downstream of it, has room (or the sink takes S5).
  always_comb begin
    hole_s    = bus.out_ready;
    advance_s = {NUM_STAGES{1'b0}};
    for (int k = NUM_STAGES; k >= 1; k--) begin
      hole_s       = hole_s || !stages_s[k].valid;
      advance_s[k] = hole_s;
    end
  end

  assign in_ready_s = advance_s[1] && !bus.flush && !reset;

  // Incoming request presented to the first stage.
  always_comb begin
    request_s.valid  = bus.in_valid && in_ready_s;
    request_s.data   = bus.in_x;
    request_s.amount = bus.in_amount;
    request_s.tag    = bus.in_tag;
  end

  for (genvar k = 1; k <= NUM_STAGES; k++) begin : g_stage
    if (k == 1) begin : g_first
      left_shift_stage #(
        .SHIFT   (stage_shift(k)),
        .BIT_IDX (AMT_W - k)
      ) u_stage (
        .clock   (clock),
        .reset   (reset),
        .flush   (bus.flush),
        .advance (advance_s[k]),
        .prev    (request_s),
        .cur     (stages_s[k])
      );
    end else begin : g_next
      left_shift_stage #(
        .SHIFT   (stage_shift(k)),
        .BIT_IDX (AMT_W - k)
      ) u_stage (
        .clock   (clock),
        .reset   (reset),
        .flush   (bus.flush),
        .advance (advance_s[k]),
        .prev    (stages_s[k-1]),
        .cur     (stages_s[k])
      );
    end
  end

  assign bus.in_ready  = in_ready_s;
  assign bus.out_valid = stages_s[NUM_STAGES].valid;
  assign bus.out_data  = stages_s[NUM_STAGES].data;
  assign bus.out_tag   = stages_s[NUM_STAGES].tag;

endmodule

// File: tb/tb_pipelined_left_shifter.sv
// Self-checking bench: directed vectors plus a queue scoreboard that
// predicts every accepted request as x << amount in acceptance order.
module tb_pipelined_left_shifter;
  import pipelined_left_shifter_pkg::*;

  logic clock = 1'b0;
  logic reset;

  pipelined_left_shifter_if bus();

  pipelined_left_shifter dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  tag;
  } exp_t;

  typedef struct {
    logic [31:0] x;
    logic [4:0]  amt;
    logic [3:0]  tag;
    logic [31:0] exp;
  } vec_t;

  exp_t        sb_q[$];
  vec_t        vecs[10];
  int          checks = 0;
  int          errors = 0;
  int          run_len = 0;
  int          max_run = 0;
  logic        prev_hold = 1'b0;
  logic [31:0] prev_data;
  logic [3:0]  prev_tag;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    bus.in_valid  = 1'b0;
    bus.flush     = 1'b0;
  endtask

  task automatic drain(input string name);
    idle();
    bus.out_ready = 1'b1;
    for (int i = 0; i < 20 && sb_q.size() != 0; i++) step();
    step();
    check(name, sb_q.size(), 0);
  endtask

  // One request, exact-latency and value check.
  task automatic send_single(input logic [31:0] x, input logic [4:0] amt,
                             input logic [3:0] tag, input logic [31:0] exp);
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_x      = x;
    bus.in_amount = amt;
    bus.in_tag    = tag;
    #1;
    check("single_in_ready", bus.in_ready, 1);
    step();
    bus.in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("single_early_valid", bus.out_valid, 0);
      step();
    end
    check("single_valid", bus.out_valid, 1);
    check("single_data", bus.out_data, exp);
    check("single_tag", bus.out_tag, tag);
    step();
  endtask

  // Scoreboard monitor, sampled on the falling edge.
  initial begin
    forever begin
      @(negedge clock);
      if (reset) begin
        sb_q.delete();
        prev_hold = 1'b0;
        run_len   = 0;
      end else begin
        if (prev_hold)
          check("hold_stable", {bus.out_data, bus.out_tag}, {prev_data, prev_tag});
        if (bus.out_valid && bus.out_ready && !bus.flush) begin
          if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_output: got data %0h tag %0h expected none",
                     bus.out_data, bus.out_tag);
          end else begin
            exp_t e;
            e = sb_q.pop_front();
            check("sb_result", {bus.out_data, bus.out_tag}, e);
          end
        end
        if (bus.in_valid && bus.in_ready)
          sb_q.push_back({bus.in_x << bus.in_amount, bus.in_tag});
        if (bus.flush) sb_q.delete();
        prev_hold = bus.out_valid && !bus.out_ready && !bus.flush;
        prev_data = bus.out_data;
        prev_tag  = bus.out_tag;
        run_len   = bus.out_valid ? run_len + 1 : 0;
        if (run_len > max_run) max_run = run_len;
      end
    end
  end

  initial begin
    int accepts;
    int seen;
    int sent;
    int cyc;

    vecs[0] = '{32'h0000_0001, 5'd31, 4'h3, 32'h8000_0000};
    vecs[1] = '{32'hDEAD_BEEF, 5'd0,  4'h5, 32'hDEAD_BEEF};
    vecs[2] = '{32'hDEAD_BEEF, 5'd4,  4'h6, 32'hEADB_EEF0};
    vecs[3] = '{32'hFFFF_FFFF, 5'd16, 4'h7, 32'hFFFF_0000};
    vecs[4] = '{32'h1234_5678, 5'd8,  4'h8, 32'h3456_7800};
    vecs[5] = '{32'h8000_0001, 5'd1,  4'h9, 32'h0000_0002};
    vecs[6] = '{32'h0000_FFFF, 5'd31, 4'hA, 32'h8000_0000};
    vecs[7] = '{32'hAAAA_AAAA, 5'd1,  4'hB, 32'h5555_5554};
    vecs[8] = '{32'h0F0F_0F0F, 5'd3,  4'hC, 32'h7878_7878};
    vecs[9] = '{32'h0000_0003, 5'd30, 4'hD, 32'hC000_0000};

    reset         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_x      = 32'h0;
    bus.in_amount = 5'd0;
    bus.in_tag    = 4'h0;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b0;

    // Reset state
    step();
    step();
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_data", bus.out_data, 0);
    check("rst_out_tag", bus.out_tag, 0);
    check("rst_in_ready", bus.in_ready, 0);
    reset = 1'b0;
    #1;
    check("post_rst_in_ready", bus.in_ready, 1);
    check("post_rst_out_valid", bus.out_valid, 0);
    check("post_rst_out_data", bus.out_data, 0);
    step();

    // Directed vectors
    for (int i = 0; i < 10; i++)
      send_single(vecs[i].x, vecs[i].amt, vecs[i].tag, vecs[i].exp);

    // Back-to-back stream
    bus.out_ready = 1'b1;
    max_run = 0;
    for (int n = 0; n < 32; n++) begin
      bus.in_valid  = 1'b1;
      bus.in_x      = 32'hDEAD_BEEF;
      bus.in_amount = n[4:0];
      bus.in_tag    = n[3:0];
      #1;
      check("stream_in_ready", bus.in_ready, 1);
      step();
    end
    idle();
    for (int i = 0; i < 8; i++) step();
    check("stream_run", max_run, 32);
    check("stream_drained", sb_q.size(), 0);

    // Backpressure
    bus.out_ready = 1'b0;
    accepts = 0;
    for (int i = 0; i < 10; i++) begin
      bus.in_valid  = 1'b1;
      bus.in_x      = 32'h1357_9BDF + i;
      bus.in_amount = i[4:0];
      bus.in_tag    = i[3:0];
      #1;
      if (bus.in_ready) accepts++;
      step();
    end
    check("bp_accepts", accepts, 5);
    check("bp_in_ready", bus.in_ready, 0);
    drain("bp_drained");

    // Flush with requests in flight
    bus.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.in_valid  = 1'b1;
      bus.in_x      = 32'hCAFE_0000 | i;
      bus.in_amount = 5'(i + 1);
      bus.in_tag    = i[3:0];
      step();
    end
    bus.flush     = 1'b1;
    bus.in_x      = 32'hFFFF_FFFF;
    bus.in_amount = 5'd1;
    bus.in_tag    = 4'hF;
    #1;
    check("flush_in_ready", bus.in_ready, 0);
    step();
    idle();
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      if (bus.out_valid) seen++;
      step();
    end
    check("flush_no_output", seen, 0);
    check("flush_sb_empty", sb_q.size(), 0);
    send_single(32'h0000_00F0, 5'd4, 4'h2, 32'h0000_0F00);

    // Asynchronous reset mid-stream
    bus.out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      bus.in_valid  = 1'b1;
      bus.in_x      = 32'h0BAD_F00D + i;
      bus.in_amount = i[4:0];
      bus.in_tag    = i[3:0];
      step();
    end
    bus.in_valid = 1'b0;
    check("pre_reset_valid", bus.out_valid, 1);
    #2;
    reset = 1'b1;
    #1;
    check("async_rst_valid", bus.out_valid, 0);
    check("async_rst_data", bus.out_data, 0);
    check("async_rst_tag", bus.out_tag, 0);
    check("async_rst_in_ready", bus.in_ready, 0);
    step();
    step();
    reset = 1'b0;
    #1;
    check("rst_release_in_ready", bus.in_ready, 1);
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      if (bus.out_valid) seen++;
      step();
    end
    check("rst_no_stale", seen, 0);

    // Random traffic with random backpressure
    sent = 0;
    cyc  = 0;
    while (sent < 10000 && cyc < 40000) begin
      bus.in_valid  = ($urandom_range(0, 9) < 8);
      bus.out_ready = ($urandom_range(0, 3) != 0);
      bus.in_x      = $urandom;
      bus.in_amount = 5'($urandom_range(0, 31));
      bus.in_tag    = 4'($urandom_range(0, 15));
      #1;
      if (bus.in_valid && bus.in_ready) sent++;
      step();
      cyc++;
    end
    check("random_sent", sent, 10000);
    drain("random_drained");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
